reg_file_wr_decode: RTL and testbench

//  32 x 32-bit CPU register file. Writes go through a 5-to-32 one-hot write

---
 rtl/cpu_pkg.sv | 13 +
 rtl/decoder5_32.sv | 18 +
 rtl/reg_file_wr_decode.sv | 125 ++++++++++++
 tb/tb_reg_file_wr_decode.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the register file slice.
package cpu_pkg;

    localparam int unsigned CPU_DW   = 32;
    localparam int unsigned CPU_AW   = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

endpackage

// File: rtl/decoder5_32.sv
// Address to one-hot select decoder; output is all-zero when disabled.
module decoder5_32 #(
    parameter int unsigned AW = 5
) (
    input  logic              en,
    input  logic [AW-1:0]     addr,
    output logic [2**AW-1:0]  onehot
);

    // Single select line raised for the addressed register when enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_wr_decode.sv
// Register file with one-hot write decode, two combinational read ports and
// a sequential clear engine zeroing r1..r(DEPTH-1), one register per cycle.
module reg_file_wr_decode
    import cpu_pkg::*;
#(
    parameter int unsigned DW     = CPU_DW,
    parameter int unsigned AW     = CPU_AW,
    parameter bit          BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          wr_drop
);

    localparam int unsigned   DEPTH    = 2**AW;
    localparam logic [AW-1:0] CNT_LAST = '1;
    localparam logic [AW-1:0] ADDR_R0  = AW'(REG_ZERO);

    clr_state_e       state;
    logic [AW-1:0]    cnt;
    logic [DW-1:0]    mem [DEPTH];
    logic             wr_valid;
    logic             dec_en;
    logic [AW-1:0]    dec_addr;
    logic [DEPTH-1:0] sel;

    // A write that targets a real register (r0 writes vanish silently)
    assign wr_valid = we && (waddr != ADDR_R0);

    // One decoder serves both paths: clear counter in CLEAR, write address otherwise
    always_comb begin
        dec_en   = (state == CLEAR) || we;
        dec_addr = (state == CLEAR) ? cnt : waddr;
    end

    decoder5_32 #(.AW(AW)) u_dec (
        .en     (dec_en),
        .addr   (dec_addr),
        .onehot (sel)
    );

    // Storage update and clear-engine FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_drop <= 1'b0;
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (sel[i] && (i != REG_ZERO)) begin
                            mem[i] <= wdata;
                        end
                    end
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= AW'(1);
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    wr_drop <= wr_valid;
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (sel[i] && (i != REG_ZERO)) begin
                            mem[i] <= '0;
                        end
                    end
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    clr_busy <= 1'b0;
                    wr_drop  <= 1'b0;
                end
            endcase
        end
    end

    // Read port A: r0 forced to zero, optional same-cycle forwarding in IDLE
    always_comb begin
        rdata_a = '0;
        if (raddr_a != ADDR_R0) begin
            if (BYPASS && (state == IDLE) && wr_valid && (waddr == raddr_a)) begin
                rdata_a = wdata;
            end else begin
                rdata_a = mem[raddr_a];
            end
        end
    end

    // Read port B: same structure as port A
    always_comb begin
        rdata_b = '0;
        if (raddr_b != ADDR_R0) begin
            if (BYPASS && (state == IDLE) && wr_valid && (waddr == raddr_b)) begin
                rdata_b = wdata;
            end else begin
                rdata_b = mem[raddr_b];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_wr_decode.sv
// Bench for reg_file_wr_decode: two instances (forwarding on/off) share inputs
// and are compared every cycle against a register-array reference model.
module tb_reg_file_wr_decode;

    logic        clk = 1'b0;
    logic        rst, we, clr_req;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic [31:0] rdata_a1, rdata_b1, rdata_a0, rdata_b0;
    logic        clr_busy1, wr_drop1, clr_busy0, wr_drop0;

    always #5 clk = ~clk;

    reg_file_wr_decode #(.DW(32), .AW(5), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
        .clr_req(clr_req), .clr_busy(clr_busy1), .wr_drop(wr_drop1)
    );

    reg_file_wr_decode #(.DW(32), .AW(5), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
        .clr_req(clr_req), .clr_busy(clr_busy0), .wr_drop(wr_drop0)
    );

    // Reference model: register contents, clear progress as "registers left"
    logic [31:0] m_mem [32];
    bit          m_busy;
    bit          m_drop;
    int          m_left;

    int    npass  = 0;
    int    ntotal = 0;
    bit    chk_en = 1'b0;
    logic  last_busy;
    logic [31:0] last_ra1, last_ra0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && !m_busy && we && (waddr == a)) return wdata;
        return m_mem[a];
    endfunction

    // One clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic tick();
        @(negedge clk);
        last_busy = clr_busy1;
        last_ra1  = rdata_a1;
        last_ra0  = rdata_a0;
        if (chk_en) begin
            chk("rd_a_byp",   rdata_a1,  exp_rd(raddr_a, 1'b1));
            chk("rd_b_byp",   rdata_b1,  exp_rd(raddr_b, 1'b1));
            chk("rd_a_nobyp", rdata_a0,  exp_rd(raddr_a, 1'b0));
            chk("rd_b_nobyp", rdata_b0,  exp_rd(raddr_b, 1'b0));
            chk("busy_byp",   {31'd0, clr_busy1}, {31'd0, m_busy});
            chk("busy_nobyp", {31'd0, clr_busy0}, {31'd0, m_busy});
            chk("drop_byp",   {31'd0, wr_drop1},  {31'd0, m_drop});
            chk("drop_nobyp", {31'd0, wr_drop0},  {31'd0, m_drop});
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_left = 0;
        end else if (!m_busy) begin
            m_drop = 1'b0;
            if (we && waddr != 5'd0) m_mem[waddr] = wdata;
            if (clr_req) begin
                m_busy = 1'b1;
                m_left = 31;
            end
        end else begin
            m_drop = we && (waddr != 5'd0);
            m_mem[32 - m_left] = 32'd0;
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we = 1'b0; clr_req = 1'b0;
        waddr = 5'd0; wdata = 32'd0;
    endtask

    task automatic fill(input bit rnd);
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i);
            wdata = rnd ? $urandom : 32'(i);
            raddr_a = 5'($urandom_range(0, 31)); raddr_b = 5'd31;
            tick();
        end
        idle_inputs();
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(31 - i);
            tick();
        end
    endtask

    int nb;

    initial begin
        // 1: reset then scan every address
        idle_inputs(); raddr_a = 5'd0; raddr_b = 5'd0;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        read_all();

        // 2: plain write, r0 write ignored
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; tick();
        idle_inputs(); raddr_a = 5'd5; raddr_b = 5'd0; tick();
        chk("r5_value", last_ra1, 32'hDEADBEEF);
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr_a = 5'd0; tick();
        idle_inputs(); tick();

        // 3: same-cycle forwarding vs next-cycle visibility
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr_a = 5'd7; tick();
        chk("byp_same_cycle", last_ra1, 32'hA5A5A5A5);
        chk("nobyp_old_value", last_ra0, 32'd0);
        idle_inputs(); tick();
        chk("nobyp_next_cycle", last_ra0, 32'hA5A5A5A5);

        // 4: fill with index, full clear, busy length
        fill(1'b0);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        nb = 0;
        for (int c = 1; c <= 40; c++) begin
            raddr_a = 5'($urandom_range(1, 31)); raddr_b = 5'd31;
            tick();
            if (last_busy === 1'b1) nb++; else break;
        end
        chk("clear_len_1", 32'(nb), 32'd31);
        read_all();

        // 5: dropped write at cycle 10, ignored clr_req at cycle 20
        fill(1'b1);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        nb = 0;
        for (int c = 1; c <= 40; c++) begin
            idle_inputs();
            raddr_a = 5'd3; raddr_b = 5'($urandom_range(0, 31));
            if (c == 10) begin we = 1'b1; waddr = 5'd3; wdata = 32'hFF; end
            if (c == 20) clr_req = 1'b1;
            tick();
            if (last_busy === 1'b1) nb++; else break;
        end
        idle_inputs();
        chk("clear_len_2", 32'(nb), 32'd31);
        raddr_a = 5'd3; tick();
        chk("r3_cleared", last_ra1, 32'd0);

        // 6: reset in the middle of a clear
        fill(1'b1);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        for (int c = 1; c < 12; c++) begin
            raddr_a = 5'($urandom_range(0, 31)); raddr_b = 5'($urandom_range(0, 31));
            tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        read_all();
        we = 1'b1; waddr = 5'd9; wdata = 32'h1; tick();
        idle_inputs(); raddr_a = 5'd9; tick();
        chk("r9_after_rst", last_ra0, 32'h1);

        // Random traffic with occasional clear and reset
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            clr_req = ($urandom_range(0, 49) == 0);
            we      = 1'($urandom_range(0, 1));
            waddr   = 5'($urandom_range(0, 31));
            wdata   = $urandom;
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr_b = 5'($urandom_range(0, 31));
            tick();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
